dsi_hs_lane_rx: RTL and testbench
=================================

# dsi_hs_lane_rx

HS data lane receiver for the DSI/D-PHY link: the receive-side counterpart of the HS lane transmitter. It takes unaligned 8-bit words from the lane deserializer and searches for the HS sync byte after HS entry. Once synchronised it emits byte-aligned payload, strips the HS-trail tail, and signals start and end of transmission to the lane merger above it. HS entry and exit (`hs_en`) are supplied by the lane's LP receiver.

## Interface

Parameters:
- `SYNC_TIMEOUT`, default 8: number of clk_sys cycles allowed in WAIT_SYNC without a match before an error is raised. Legal range 1..255.
- `TRAIL_DROP`, default 1: number of final aligned bytes of each burst that are discarded as trail. Legal range 0..4.

Ports (clock and reset first):
- `clk_sys` input, 1 bit: byte clock. Already decided.
- `rst_n` input, 1 bit: asynchronous, active-low reset. Already decided.
- `ser_data` input, 8 bits: deserializer word, one per cycle. Bit 0 is the earliest received bit.
- `hs_en` input, 1 bit: lane in HS mode (HS entry seen, LP-11 not yet seen). Synchronous to clk_sys.
- `out_data` output, 8 bits: aligned payload byte.
- `out_valid` output, 1 bit: `out_data` valid. No backpressure.
- `sot` output, 1 bit: qualifies the first valid byte of a burst.
- `eot` output, 1 bit: one-cycle pulse when a synchronised burst ends.
- `active` output, 1 bit: high whenever state is not IDLE.
- `sync_err` output, 1 bit: one-cycle pulse on sync timeout.

## Operation

- Input stage: `ser_data` is registered into d0 each cycle, and d0 shifts into d1. The search window is the 16-bit value {d0, d1}; window bit 0 is the oldest bit.
- The sync byte is 8'h1D, matched as window[k+7:k] for offsets k = 0..7. When several offsets match, the lowest k wins.
- FSM states: IDLE, WAIT_SYNC, ACTIVE, ERR.
  - IDLE -> WAIT_SYNC when `hs_en` = 1.
  - WAIT_SYNC -> ACTIVE on a match. The winning k is latched as `off`.
  - WAIT_SYNC -> ERR after SYNC_TIMEOUT cycles in WAIT_SYNC with no match. `sync_err` pulses on that transition.
  - WAIT_SYNC -> IDLE when `hs_en` = 0. Neither `eot` nor `sync_err` is raised in this case.
  - ACTIVE -> IDLE when `hs_en` = 0. `eot` pulses.
  - ERR -> IDLE when `hs_en` = 0. No `eot`.
  - `hs_en` = 0 takes priority over both match and timeout.
- In ACTIVE, each cycle the aligned byte window[off+7:off] enters a delay line of depth TRAIL_DROP.
  - A byte is emitted on `out_data` only once TRAIL_DROP newer bytes are behind it.
  - With TRAIL_DROP = 0, every byte is emitted.
- On exit from ACTIVE, bytes still held in the delay line and in d0/d1 are discarded.
- `sot` is asserted together with `out_valid` on the first emitted byte of a burst only.
- If a burst ends before any byte is emitted, `eot` still pulses and `sot` never asserts.
- The sync timeout counter is 8 bits wide. It is loaded on entry to WAIT_SYNC and cleared in every other state.

## Timing

- Reset values: `out_data` = 0, `out_valid` = 0, `sot` = 0, `eot` = 0, `active` = 0, `sync_err` = 0, state = IDLE, d0/d1 = 0, delay line empty.
- Reset asserted mid-burst returns the block to these values immediately. No `eot` is produced.
- All outputs are registered.
- Latency: let T be the cycle in which ser_data holds the word W(n), where {W(n), W(n-1)} contains the sync.
  - The first payload byte is window content in cycle T+2.
  - That byte appears on `out_data` with `out_valid` = 1 in cycle T+3+TRAIL_DROP.
  - After that, one byte per cycle, with no gaps while `hs_en` = 1.
- `hs_en` low is sampled in cycle L. From cycle L+1:
  - `out_valid` = 0.
  - `eot` = 1 for exactly cycle L+1 (only if the state was ACTIVE).
  - `active` = 0.
- `hs_en` returning high in cycle L+1 or later starts a new WAIT_SYNC normally. Back-to-back bursts therefore need no idle gap beyond one cycle.
- `sync_err` is asserted in the cycle after the SYNC_TIMEOUT-th unmatched WAIT_SYNC cycle. `active` stays 1 through ERR.

## Test plan

- Offset 0, TRAIL_DROP = 0: zeros, then 8'h1D, then payload 8'hA5, 8'h3C, then `hs_en` low -> `out_data` A5 (with `sot`), then 3C; `eot` pulses one cycle after `hs_en` falls.
- Offset 5: stream payload 8'h01..8'h10 bit-shifted by 5 after the sync -> exactly 16 bytes, 01..10 in order, latency T+3+TRAIL_DROP; no byte output before the sync.
- TRAIL_DROP = 2: send sync + 6 bytes + 2 trail bytes (all 8'hFF), then `hs_en` low -> only the 6 payload bytes are output, `eot` = 1 once.
- Timeout, SYNC_TIMEOUT = 8: `hs_en` high with all-zero input -> `sync_err` pulses in cycle 9 and `active` stays 1 until `hs_en` falls; no `out_valid`, no `eot`.
- `hs_en` drops during WAIT_SYNC, then rises and a valid sync follows -> no `sync_err` or `eot` for the first burst; the second burst delivers correct bytes with `sot`.
- Reset asserted mid-ACTIVE -> all outputs 0 immediately; the next burst after reset release synchronises and delivers correct data.

Source files
------------

// File: rtl/dsi_hs_lane_rx_if.sv
// Lane-side bundle between the deserializer/LP receiver and the HS lane receiver.
// Latency: none, wires only.
// Backpressure: none; payload is a plain valid-qualified stream.
interface dsi_hs_lane_rx_if;
  logic [7:0] ser_data;
  logic       hs_en;
  logic [7:0] out_data;
  logic       out_valid;
  logic       sot;
  logic       eot;
  logic       active;
  logic       sync_err;

  // Upstream side: supplies deserializer words and HS mode, sees the aligned stream.
  modport master (
    output ser_data, hs_en,
    input  out_data, out_valid, sot, eot, active, sync_err
  );

  // Receiver side.
  modport slave (
    input  ser_data, hs_en,
    output out_data, out_valid, sot, eot, active, sync_err
  );
endinterface

// File: rtl/dsi_hs_lane_rx.sv
// HS lane receiver: finds the 8'h1D sync at any bit offset, emits aligned payload, drops the HS trail.
// Latency: first payload byte on out_data 3+TRAIL_DROP cycles after the word completing the sync.
// Backpressure: none; one byte per cycle while hs_en stays high, out_valid has no ready.
module dsi_hs_lane_rx #(
  parameter int SYNC_TIMEOUT = 8,
  parameter int TRAIL_DROP   = 1
) (
  input logic             clk_sys,
  input logic             rst_n,
  dsi_hs_lane_rx_if.slave lane
);

  localparam logic [7:0] SYNC_BYTE = 8'h1D;
  localparam int         DLW       = (TRAIL_DROP == 0) ? 1 : TRAIL_DROP;
  localparam logic [7:0] TMO_LAST  = 8'(SYNC_TIMEOUT - 1);
  localparam logic [2:0] FILL_FULL = 3'(TRAIL_DROP);

  typedef enum logic [1:0] {IDLE, WAIT_SYNC, ACTIVE, ERR} state_t;

  state_t      state, state_nxt;
  logic [7:0]  d0, d1;
  logic [15:0] win;
  logic        match;
  logic [2:0]  match_k;
  logic [2:0]  off;
  logic [7:0]  tmo_cnt;
  logic        timeout;
  logic        burst_end;
  logic        shift_en;
  logic        emit;
  logic [7:0]  aligned;
  logic [7:0]  emit_byte;
  logic [7:0]  dl [DLW];
  logic [2:0]  fill;
  logic        sot_done;

  logic [7:0]  out_data_r;
  logic        out_valid_r, sot_r, eot_r, active_r, sync_err_r;

  // Window bit 0 is the oldest received bit: d1 is the older word.
  assign win     = {d0, d1};
  assign aligned = win[off +: 8];

  // Sync search across all eight bit offsets; the descending loop leaves the lowest match.
  always_comb begin
    match   = 1'b0;
    match_k = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (win[k +: 8] == SYNC_BYTE) begin
        match   = 1'b1;
        match_k = 3'(k);
      end
    end
  end

  // Next state; dropping hs_en overrides both a match and a timeout.
  always_comb begin
    state_nxt = state;
    timeout   = 1'b0;
    burst_end = 1'b0;
    case (state)
      IDLE: begin
        if (lane.hs_en) state_nxt = WAIT_SYNC;
      end
      WAIT_SYNC: begin
        if (!lane.hs_en) begin
          state_nxt = IDLE;
        end else if (match) begin
          state_nxt = ACTIVE;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt = ERR;
          timeout   = 1'b1;
        end
      end
      ACTIVE: begin
        if (!lane.hs_en) begin
          state_nxt = IDLE;
          burst_end = 1'b1;
        end
      end
      ERR: begin
        if (!lane.hs_en) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Emit a byte only once TRAIL_DROP newer bytes sit behind it in the delay line.
  always_comb begin
    shift_en  = (state == ACTIVE) && lane.hs_en;
    emit      = 1'b0;
    emit_byte = 8'h00;
    if (TRAIL_DROP == 0) begin
      emit      = shift_en;
      emit_byte = aligned;
    end else begin
      emit      = shift_en && (fill == FILL_FULL);
      emit_byte = dl[DLW-1];
    end
  end

  // State register.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Input stage; leaving ACTIVE flushes the stale words so the next burst searches clean data.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      d0 <= 8'h00;
      d1 <= 8'h00;
    end else if (burst_end) begin
      d0 <= 8'h00;
      d1 <= 8'h00;
    end else begin
      d0 <= lane.ser_data;
      d1 <= d0;
    end
  end

  // Sync timeout counter: starts at zero on entry to WAIT_SYNC, held at zero elsewhere.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)                                              tmo_cnt <= 8'd0;
    else if (state == WAIT_SYNC && state_nxt == WAIT_SYNC)   tmo_cnt <= tmo_cnt + 8'd1;
    else                                                     tmo_cnt <= 8'd0;
  end

  // Latch the winning bit offset for the whole burst.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)                                         off <= 3'd0;
    else if (state == WAIT_SYNC && state_nxt == ACTIVE) off <= match_k;
  end

  // Trail delay line; anything still held when the burst ends is simply forgotten.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DLW; i++) dl[i] <= 8'h00;
      fill <= 3'd0;
    end else if (shift_en) begin
      for (int i = DLW - 1; i > 0; i--) dl[i] <= dl[i-1];
      dl[0] <= aligned;
      if (fill != FILL_FULL) fill <= fill + 3'd1;
    end else begin
      fill <= 3'd0;
    end
  end

  // Registered outputs; sot marks only the first emitted byte of each burst.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r  <= 8'h00;
      out_valid_r <= 1'b0;
      sot_r       <= 1'b0;
      eot_r       <= 1'b0;
      active_r    <= 1'b0;
      sync_err_r  <= 1'b0;
      sot_done    <= 1'b0;
    end else begin
      if (emit) out_data_r <= emit_byte;
      out_valid_r <= emit;
      sot_r       <= emit && !sot_done;
      sot_done    <= shift_en && (sot_done || emit);
      eot_r       <= burst_end;
      active_r    <= (state_nxt != IDLE);
      sync_err_r  <= timeout;
    end
  end

  assign lane.out_data  = out_data_r;
  assign lane.out_valid = out_valid_r;
  assign lane.sot       = sot_r;
  assign lane.eot       = eot_r;
  assign lane.active    = active_r;
  assign lane.sync_err  = sync_err_r;

endmodule

// File: tb/tb_dsi_hs_lane_rx.sv
// Directed bench for dsi_hs_lane_rx: two instances (TRAIL_DROP 0 and 2) share one input stream.
// Expected bytes are queued per instance when a burst is driven and popped as out_valid appears.
// Bursts are built as a byte stream (zeros, sync, payload) delayed by a chosen bit offset.
`timescale 1ns/1ps
module tb_dsi_hs_lane_rx;

  localparam int TD_A = 0;
  localparam int TD_B = 2;
  localparam int TMO  = 8;

  typedef struct packed {
    logic [7:0] d;
    logic       s;
  } exp_t;

  logic clk_sys = 1'b0;
  logic rst_n;
  always #5 clk_sys = ~clk_sys;

  dsi_hs_lane_rx_if if_a ();
  dsi_hs_lane_rx_if if_b ();
  assign if_b.ser_data = if_a.ser_data;
  assign if_b.hs_en    = if_a.hs_en;

  dsi_hs_lane_rx #(.SYNC_TIMEOUT(TMO), .TRAIL_DROP(TD_A)) u_dut_a (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .lane    (if_a.slave)
  );

  dsi_hs_lane_rx #(.SYNC_TIMEOUT(TMO), .TRAIL_DROP(TD_B)) u_dut_b (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .lane    (if_b.slave)
  );

  exp_t       qa[$];
  exp_t       qb[$];
  logic [7:0] pl[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int sot_a_cyc, sot_b_cyc, eot_a_cnt, eot_b_cnt, err_a_cnt, err_b_cnt, err_a_cyc, err_b_cyc;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic clr_counts();
    sot_a_cyc = -1; sot_b_cyc = -1;
    eot_a_cnt = 0;  eot_b_cnt = 0;
    err_a_cnt = 0;  err_b_cnt = 0;
    err_a_cyc = -1; err_b_cyc = -1;
  endtask

  // Scoreboard side: pop and compare every byte each instance emits.
  always @(negedge clk_sys) begin : mon
    exp_t e;
    if (if_a.out_valid === 1'b1) begin
      chk("a_byte_expected", 32'(qa.size() != 0), 32'd1);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        chk("a_data", 32'(if_a.out_data), 32'(e.d));
        chk("a_sot", 32'(if_a.sot), 32'(e.s));
      end
    end
    if (if_b.out_valid === 1'b1) begin
      chk("b_byte_expected", 32'(qb.size() != 0), 32'd1);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        chk("b_data", 32'(if_b.out_data), 32'(e.d));
        chk("b_sot", 32'(if_b.sot), 32'(e.s));
      end
    end
    if (if_a.sot === 1'b1) sot_a_cyc = cyc;
    if (if_b.sot === 1'b1) sot_b_cyc = cyc;
    if (if_a.eot === 1'b1) eot_a_cnt++;
    if (if_b.eot === 1'b1) eot_b_cnt++;
    if (if_a.sync_err === 1'b1) begin err_a_cnt++; err_a_cyc = cyc; end
    if (if_b.sync_err === 1'b1) begin err_b_cnt++; err_b_cyc = cyc; end
  end

  // Drive one burst: s0 zero bytes, sync, pl[], two more words, then hs_en low.
  // k is the bit offset of the sync. abort_j >= 0 stops before driving word abort_j.
  task automatic burst(input int s0, input int k, input int abort_j);
    logic [7:0]  bq[$];
    logic [15:0] w2;
    logic [7:0]  prev;
    int n, base;
    n = pl.size();
    for (int i = 0; i < s0; i++) bq.push_back(8'h00);
    bq.push_back(8'h1D);
    for (int i = 0; i < n; i++) bq.push_back(pl[i]);
    repeat (3) bq.push_back(8'h00);
    for (int i = 0; i < n; i++) begin
      qa.push_back(exp_t'({pl[i], 1'(i == 0)}));
      if (i < n - TD_B) qb.push_back(exp_t'({pl[i], 1'(i == 0)}));
    end
    base = cyc;
    for (int j = 0; j <= s0 + n + 2; j++) begin
      if (j == abort_j) return;
      prev = (j == 0) ? 8'h00 : bq[j-1];
      w2 = {bq[j], prev};
      w2 = w2 >> (8 - k);
      if_a.ser_data = w2[7:0];
      if_a.hs_en    = 1'b1;
      step();
      if (j == 0) clr_counts();
    end
    if_a.hs_en    = 1'b0;
    if_a.ser_data = 8'h00;
    step();
    chk("a_eot_pulse", 32'(if_a.eot), 32'd1);
    chk("b_eot_pulse", 32'(if_b.eot), 32'd1);
    chk("a_active_off", 32'(if_a.active), 32'd0);
    chk("a_valid_off", 32'(if_a.out_valid), 32'd0);
    chk("a_no_early_eot", 32'(eot_a_cnt), 32'd0);
    chk("b_no_early_eot", 32'(eot_b_cnt), 32'd0);
    chk("a_no_sync_err", 32'(err_a_cnt), 32'd0);
    chk("a_all_bytes", 32'(qa.size()), 32'd0);
    chk("b_all_bytes", 32'(qb.size()), 32'd0);
    chk("a_first_cycle", 32'(sot_a_cyc), 32'(base + s0 + 4 + TD_A));
    chk("b_first_cycle", 32'(sot_b_cyc), (n > TD_B) ? 32'(base + s0 + 4 + TD_B) : 32'hFFFF_FFFF);
  endtask

  initial begin : main
    int base;
    rst_n = 1'b0;
    if_a.ser_data = 8'h00;
    if_a.hs_en    = 1'b0;
    clr_counts();
    repeat (3) step();
    chk("rst_a_data", 32'(if_a.out_data), 32'd0);
    chk("rst_a_valid", 32'(if_a.out_valid), 32'd0);
    chk("rst_a_sot", 32'(if_a.sot), 32'd0);
    chk("rst_a_eot", 32'(if_a.eot), 32'd0);
    chk("rst_a_active", 32'(if_a.active), 32'd0);
    chk("rst_a_sync_err", 32'(if_a.sync_err), 32'd0);
    chk("rst_b_valid", 32'(if_b.out_valid), 32'd0);
    chk("rst_b_active", 32'(if_b.active), 32'd0);
    rst_n = 1'b1;
    step();
    step();

    // Offset 0, two-byte burst: instance B drops both as trail and never raises sot.
    pl = {8'hA5, 8'h3C};
    burst(1, 0, -1);

    // Offset 5, 16 bytes, started back-to-back one cycle after the previous eot.
    pl = {};
    for (int i = 1; i <= 16; i++) pl.push_back(8'(i));
    burst(2, 5, -1);

    // Six payload bytes followed by two FF trail bytes.
    pl = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'hFF, 8'hFF};
    burst(0, 3, -1);

    // Offset 7 with random payload.
    pl = {};
    repeat (5) pl.push_back(8'($urandom_range(0, 255)));
    burst(3, 7, -1);
    step();

    // Sync timeout with all-zero input.
    base = cyc;
    if_a.hs_en    = 1'b1;
    if_a.ser_data = 8'h00;
    step();
    clr_counts();
    repeat (10) step();
    chk("tmo_a_active", 32'(if_a.active), 32'd1);
    chk("tmo_b_active", 32'(if_b.active), 32'd1);
    chk("tmo_a_err_cnt", 32'(err_a_cnt), 32'd1);
    chk("tmo_a_err_cycle", 32'(err_a_cyc), 32'(base + 9));
    chk("tmo_b_err_cycle", 32'(err_b_cyc), 32'(base + 9));
    step();
    chk("tmo_a_still_active", 32'(if_a.active), 32'd1);
    if_a.hs_en = 1'b0;
    step();
    chk("tmo_a_active_drop", 32'(if_a.active), 32'd0);
    chk("tmo_a_no_eot", 32'(if_a.eot), 32'd0);
    step();
    chk("tmo_a_eot_cnt", 32'(eot_a_cnt), 32'd0);
    chk("tmo_b_eot_cnt", 32'(eot_b_cnt), 32'd0);
    chk("tmo_a_err_once", 32'(err_a_cnt), 32'd1);

    // hs_en drops during WAIT_SYNC, then a proper burst follows immediately.
    base = cyc;
    if_a.hs_en = 1'b1;
    step();
    clr_counts();
    step();
    step();
    chk("drop_a_active", 32'(if_a.active), 32'd1);
    if_a.hs_en = 1'b0;
    step();
    chk("drop_a_active_off", 32'(if_a.active), 32'd0);
    chk("drop_a_no_eot", 32'(if_a.eot), 32'd0);
    chk("drop_b_no_eot", 32'(if_b.eot), 32'd0);
    chk("drop_a_eot_cnt", 32'(eot_a_cnt), 32'd0);
    chk("drop_a_err_cnt", 32'(err_a_cnt), 32'd0);
    chk("drop_b_err_cnt", 32'(err_b_cnt), 32'd0);
    pl = {8'hC3, 8'h5A, 8'h00, 8'h1D, 8'hE7};
    burst(1, 2, -1);

    // Reset in the middle of an active burst.
    pl = {};
    for (int i = 0; i < 10; i++) pl.push_back(8'(8'h40 + i));
    burst(1, 3, 7);
    chk("mid_a_streaming", 32'(if_a.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_a_data", 32'(if_a.out_data), 32'd0);
    chk("mid_rst_a_valid", 32'(if_a.out_valid), 32'd0);
    chk("mid_rst_a_sot", 32'(if_a.sot), 32'd0);
    chk("mid_rst_a_eot", 32'(if_a.eot), 32'd0);
    chk("mid_rst_a_active", 32'(if_a.active), 32'd0);
    chk("mid_rst_a_sync_err", 32'(if_a.sync_err), 32'd0);
    chk("mid_rst_b_active", 32'(if_b.active), 32'd0);
    if_a.hs_en    = 1'b0;
    if_a.ser_data = 8'h00;
    step();
    step();
    qa.delete();
    qb.delete();
    clr_counts();
    rst_n = 1'b1;
    step();
    chk("mid_rst_a_no_eot", 32'(eot_a_cnt), 32'd0);
    pl = {8'h9E, 8'h01, 8'h7F, 8'h80};
    burst(2, 6, -1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
